// File: rtl/ram_arbiter_2m.sv
// Two-master round-robin arbiter for a single-port byte RAM. It supports a bounded
// bus lock and returns read data with a one-cycle valid strobe for each master.
module ram_arbiter_2m #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  logic       last_gnt_q, last_gnt_d;
  owner_e     owner_q, owner_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic [1:0] gnt;
  logic [7:0] cnt_inc;

  // A lock owner below its budget wins outright. Otherwise the grant goes to the sole
  // requester, or to the master that was not granted last.
  always_comb begin
    gnt = 2'b00;
    if (owner_q == OWN_M0 && m0_req && lock_cnt_q < MAX_CNT) begin
      gnt = 2'b01;
    end else if (owner_q == OWN_M1 && m1_req && lock_cnt_q < MAX_CNT) begin
      gnt = 2'b10;
    end else begin
      case ({m1_req, m0_req})
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (!rst_n) gnt = 2'b00;
  end

  assign cnt_inc = (lock_cnt_q >= MAX_CNT) ? MAX_CNT : lock_cnt_q + 8'd1;

  // An idle cycle or an unlocked grant drops ownership.
  always_comb begin
    last_gnt_d = last_gnt_q;
    owner_d    = OWN_NONE;
    lock_cnt_d = 8'd0;
    rvalid_d   = 2'b00;
    if (gnt[0]) begin
      last_gnt_d  = 1'b0;
      rvalid_d[0] = ~m0_we;
      if (m0_lock) begin
        owner_d    = OWN_M0;
        lock_cnt_d = (owner_q == OWN_M0) ? cnt_inc : 8'd1;
      end
    end else if (gnt[1]) begin
      last_gnt_d  = 1'b1;
      rvalid_d[1] = ~m1_we;
      if (m1_lock) begin
        owner_d    = OWN_M1;
        lock_cnt_d = (owner_q == OWN_M1) ? cnt_inc : 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
      owner_q    <= OWN_NONE;
      lock_cnt_q <= 8'd0;
      rvalid_q   <= 2'b00;
    end else begin
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign ram_we    = (gnt[0] & m0_we) | (gnt[1] & m1_we);
  assign ram_addr  = gnt[1] ? m1_addr : m0_addr;
  assign ram_wdata = gnt[1] ? m1_wdata : m0_wdata;
  assign rdata     = ram_rdata;
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];

endmodule
